// File: rtl/spinn_link_pkg.sv
// Shared definitions for the SpiNNaker 2-of-7 link transmitter.
// Holds the nibble/EOP toggle masks, a nibble-to-mask helper, the symbol
// counts for short and long packets, the header bit positions and the
// transmitter state encoding.
package spinn_link_pkg;

  localparam int SYM_IDX_W = 5;

  // Symbol counts include the terminating EOP
  localparam int SHORT_SYMS = 11;
  localparam int LONG_SYMS  = 19;
  localparam logic [SYM_IDX_W-1:0] SHORT_LAST = SYM_IDX_W'(SHORT_SYMS - 1);
  localparam logic [SYM_IDX_W-1:0] LONG_LAST  = SYM_IDX_W'(LONG_SYMS - 1);

  localparam int HDR_PARITY_BIT  = 0;
  localparam int HDR_PAYLOAD_BIT = 1;

  localparam logic [6:0] EOP_MASK = 7'h60;

  // Each entry toggles exactly two of the seven link wires
  localparam logic [6:0] SYM_CODE [16] = '{
    7'h11, 7'h12, 7'h14, 7'h18,
    7'h21, 7'h22, 7'h24, 7'h28,
    7'h41, 7'h42, 7'h44, 7'h48,
    7'h03, 7'h06, 7'h0C, 7'h09
  };

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } tx_state_e;

  function automatic logic [6:0] nibble_mask(input logic [3:0] nib);
    return SYM_CODE[nib];
  endfunction

endpackage

// File: rtl/spinn_sync.sv
// N-stage flop synchroniser for a single asynchronous level.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
module spinn_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spinn_pkt_tx.sv
// SpiNNaker link transmit stage: accepts a 72-bit packet on a valid/ready
// handshake and sends it as 2-of-7 NRZ symbols, least significant nibble
// first, followed by EOP. Each symbol waits for a transition on ack_in.
// Ports: clk, rst_n, ipkt_data/ipkt_vld/ipkt_rdy (packet input),
// data_2of7 (link data), ack_in (async link ack), tx_busy, pkt_cnt
// (packets completed), spurious_ack (sticky ack-while-idle flag).
//
// state       | meaning
// ST_IDLE     | ready for a packet; ack transitions flag spurious_ack
// ST_SEND     | one cycle: toggle the wires for symbol sym_idx
// ST_WAIT_ACK | waiting for the link ack of the last emitted symbol
module spinn_pkt_tx
  import spinn_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [71:0]          ipkt_data,
  input  logic                 ipkt_vld,
  output logic                 ipkt_rdy,
  output logic [6:0]           data_2of7,
  input  logic                 ack_in,
  output logic                 tx_busy,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic                 spurious_ack
);

  tx_state_e              state_q, state_d;
  logic [71:0]            shreg_q, shreg_d;
  logic [SYM_IDX_W-1:0]   last_q, last_d;
  logic [SYM_IDX_W-1:0]   sym_idx_q, sym_idx_d;
  logic [6:0]             data_q, data_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   spur_q, spur_d;
  logic                   ack_prev_q, ack_prev_d;
  logic                   rdy_q, rdy_d;
  logic                   busy_q, busy_d;
  logic                   ack_s;
  logic                   ack_ev;

  spinn_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_in),
    .q     (ack_s)
  );

  assign ack_ev = ack_s ^ ack_prev_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    sym_idx_d  = sym_idx_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    spur_d     = spur_q;
    ack_prev_d = ack_prev_q;

    case (state_q)
      ST_IDLE: begin
        ack_prev_d = ack_s;
        if (ack_ev) spur_d = 1'b1;
        if (ipkt_vld) begin
          shreg_d   = ipkt_data;
          last_d    = ipkt_data[HDR_PAYLOAD_BIT] ? LONG_LAST : SHORT_LAST;
          sym_idx_d = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        // ack_prev is frozen here so an ack arriving now is seen in WAIT_ACK
        if (sym_idx_q == last_q) begin
          data_d = data_q ^ EOP_MASK;
        end else begin
          data_d  = data_q ^ nibble_mask(shreg_q[3:0]);
          shreg_d = {4'h0, shreg_q[71:4]};
        end
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        ack_prev_d = ack_s;
        if (ack_ev) begin
          if (sym_idx_q != last_q) begin
            sym_idx_d = sym_idx_q + SYM_IDX_W'(1);
            state_d   = ST_SEND;
          end else begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d  = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      last_q     <= '0;
      sym_idx_q  <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      spur_q     <= 1'b0;
      ack_prev_q <= 1'b0;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      sym_idx_q  <= sym_idx_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      spur_q     <= spur_d;
      ack_prev_q <= ack_prev_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign ipkt_rdy     = rdy_q;
  assign data_2of7    = data_q;
  assign tx_busy      = busy_q;
  assign pkt_cnt      = cnt_q;
  assign spurious_ack = spur_q;

endmodule
